// File: rtl/noc_output_arbiter_if.sv
// noc_output_arbiter_if
// Bundles the requester side (req_*), the link side (out_*), the credit
// return and the status outputs of one router output-port arbiter.
//   slave  : arbiter view (consumes requests and credits, drives link/status)
//   master : requester/link view (the opposite directions)
// With NOC_ARB_STATS_EN defined, grant_cnt (4 x 16-bit packet counters) is added.
interface noc_output_arbiter_if #(
    parameter int WIDTH   = 33,
    parameter int CREDITS = 4
);
    localparam int CW = $clog2(CREDITS + 1);

    logic [3:0]         req_valid;
    logic [4*WIDTH-1:0] req_data;
    logic [3:0]         req_tail;
    logic [3:0]         req_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_tail;
    logic               credit_in;
    logic [CW-1:0]      credit_cnt;
    logic [1:0]         grant_id;
    logic               busy;
    logic               err_credit;
`ifdef NOC_ARB_STATS_EN
    logic [4*16-1:0]    grant_cnt;

    modport slave (
        input  req_valid, req_data, req_tail, credit_in,
        output req_ready, out_valid, out_data, out_tail,
               credit_cnt, grant_id, busy, err_credit, grant_cnt
    );
    modport master (
        output req_valid, req_data, req_tail, credit_in,
        input  req_ready, out_valid, out_data, out_tail,
               credit_cnt, grant_id, busy, err_credit, grant_cnt
    );
`else
    modport slave (
        input  req_valid, req_data, req_tail, credit_in,
        output req_ready, out_valid, out_data, out_tail,
               credit_cnt, grant_id, busy, err_credit
    );
    modport master (
        output req_valid, req_data, req_tail, credit_in,
        input  req_ready, out_valid, out_data, out_tail,
               credit_cnt, grant_id, busy, err_credit
    );
`endif
endinterface

// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter
// Round-robin arbiter sharing one router output port between four input
// switches. A multi-flit packet locks the port until its tail flit; every
// transfer consumes one downstream credit.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - noc_output_arbiter_if.slave: req_valid/req_data/req_tail/req_ready,
//          registered out_valid/out_data/out_tail, credit_in, credit_cnt,
//          grant_id, busy, err_credit (+ grant_cnt with NOC_ARB_STATS_EN)
// Optional feature macro: NOC_ARB_STATS_EN (per-requester completed-packet
// counters, 16 bits each, wrapping).
//
// state  | meaning
// IDLE   | round-robin search from ptr over all requesters
// LOCKED | mid-packet; only owner may transfer until its tail flit
module noc_output_arbiter #(
    parameter int WIDTH   = 33,
    parameter int CREDITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_output_arbiter_if.slave  bus
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       grant_id_q, grant_id_d;
    logic [CW-1:0]    credit_cnt_q, credit_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_tail_q, out_tail_d;
    logic             err_credit_q, err_credit_d;

    logic             cand_found;
    logic [1:0]       cand_idx;
    logic [1:0]       scan_idx;
    logic [1:0]       gnt_idx;
    logic             xfer;
    logic             xfer_tail;
    logic [WIDTH-1:0] xfer_data;

`ifdef NOC_ARB_STATS_EN
    logic [3:0][15:0] grant_cnt_q, grant_cnt_d;
`endif

    // First valid requester starting at ptr, wrapping mod 4.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = ptr_q;
        scan_idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!cand_found && bus.req_valid[scan_idx]) begin
                cand_found = 1'b1;
                cand_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        grant_id_d   = grant_id_q;
        credit_cnt_d = credit_cnt_q;
        err_credit_d = err_credit_q;
        out_data_d   = out_data_q;
        out_tail_d   = out_tail_q;
        xfer_data    = '0;

        // credit_in deliberately absent here: a returning credit is usable next cycle.
        gnt_idx = (state_q == LOCKED) ? owner_q : cand_idx;
        xfer    = (credit_cnt_q != '0) &&
                  ((state_q == LOCKED) ? bus.req_valid[owner_q] : cand_found);

        bus.req_ready = 4'b0000;
        if (xfer) bus.req_ready[gnt_idx] = 1'b1;

        for (int i = 0; i < 4; i++) begin
            if (gnt_idx == 2'(i)) xfer_data = bus.req_data[i*WIDTH +: WIDTH];
        end
        xfer_tail = bus.req_tail[gnt_idx];

        out_valid_d = xfer;
        if (xfer) begin
            out_data_d = xfer_data;
            out_tail_d = xfer_tail;
            grant_id_d = gnt_idx;
            case (state_q)
                IDLE: begin
                    if (xfer_tail) begin
                        ptr_d = gnt_idx + 2'd1;
                    end else begin
                        state_d = LOCKED;
                        owner_d = gnt_idx;
                    end
                end
                LOCKED: begin
                    if (xfer_tail) begin
                        state_d = IDLE;
                        ptr_d   = owner_q + 2'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (bus.credit_in && credit_cnt_q == CRED_MAX) err_credit_d = 1'b1;
        case ({xfer, bus.credit_in})
            2'b10:   credit_cnt_d = credit_cnt_q - CW'(1);
            2'b01:   if (credit_cnt_q != CRED_MAX) credit_cnt_d = credit_cnt_q + CW'(1);
            default: credit_cnt_d = credit_cnt_q;
        endcase
    end

`ifdef NOC_ARB_STATS_EN
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (xfer && xfer_tail) grant_cnt_d[gnt_idx] = grant_cnt_q[gnt_idx] + 16'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= 2'd0;
            owner_q      <= 2'd0;
            grant_id_q   <= 2'd0;
            credit_cnt_q <= CRED_MAX;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tail_q   <= 1'b0;
            err_credit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            grant_id_q   <= grant_id_d;
            credit_cnt_q <= credit_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tail_q   <= out_tail_d;
            err_credit_q <= err_credit_d;
        end
    end

`ifdef NOC_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) grant_cnt_q <= '0;
        else     grant_cnt_q <= grant_cnt_d;
    end
    assign bus.grant_cnt = grant_cnt_q;
`endif

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_tail   = out_tail_q;
    assign bus.credit_cnt = credit_cnt_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.busy       = (state_q == LOCKED);
    assign bus.err_credit = err_credit_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
module tb_noc_output_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    noc_output_arbiter_if #(.WIDTH(33), .CREDITS(4)) bus ();
    noc_output_arbiter #(.WIDTH(33), .CREDITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [32:0] fdat(input int i);
        return 33'h1_5A00_0000 + 33'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_xfer(input string tag, input int g, input int cnt, input logic tl);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'(1));
        chk({tag, "_gid"},   64'(bus.grant_id),  64'(g));
        chk({tag, "_data"},  64'(bus.out_data),  64'(fdat(g)));
        chk({tag, "_tail"},  64'(bus.out_tail),  64'(tl));
        chk({tag, "_cnt"},   64'(bus.credit_cnt), 64'(cnt));
    endtask

    int exp_g [5] = '{0, 1, 2, 3, 0};

    initial begin
        bus.req_valid = 4'b0000;
        bus.req_tail  = 4'b1111;
        bus.req_data  = {fdat(3), fdat(2), fdat(1), fdat(0)};
        bus.credit_in = 1'b0;
        step();
        step();
        rst = 1'b0;

        // reset state
        chk("rst_cnt",   64'(bus.credit_cnt), 64'(4));
        chk("rst_valid", 64'(bus.out_valid),  64'(0));
        chk("rst_busy",  64'(bus.busy),       64'(0));
        chk("rst_err",   64'(bus.err_credit), 64'(0));
        chk("rst_gid",   64'(bus.grant_id),   64'(0));
        chk("rst_data",  64'(bus.out_data),   64'(0));
`ifdef NOC_ARB_STATS_EN
        chk("rst_gcnt",  64'(bus.grant_cnt),  64'(0));
`endif

        // round robin over four single-flit requesters; credits returned after each accept
        bus.req_valid = 4'b1111;
        bus.req_tail  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            bus.credit_in = (k != 0);
            #1;
            chk("rr_ready", 64'(bus.req_ready), 64'(4'b0001 << exp_g[k]));
            step();
            chk_xfer("rr", exp_g[k], 3, 1'b1);
        end
        bus.req_valid = 4'b0000;
        bus.credit_in = 1'b1;
        step();
        bus.credit_in = 1'b0;
        chk("rr_cnt_back", 64'(bus.credit_cnt), 64'(4));
        chk("rr_idle_valid", 64'(bus.out_valid), 64'(0));

        // 3-flit packet from requester 1 with a 2-cycle gap; 0 and 2 held off
        bus.req_valid = 4'b0111;
        bus.req_tail  = 4'b0101;
        #1;
        chk("lk_ready1", 64'(bus.req_ready), 64'(4'b0010));
        step();
        chk_xfer("lk_f1", 1, 3, 1'b0);
        chk("lk_busy1", 64'(bus.busy), 64'(1));
        bus.req_valid = 4'b0101;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("lk_gap_ready", 64'(bus.req_ready), 64'(0));
            step();
            chk("lk_gap_valid", 64'(bus.out_valid), 64'(0));
            chk("lk_gap_busy",  64'(bus.busy),      64'(1));
        end
        bus.req_valid = 4'b0111;
        #1;
        chk("lk_ready2", 64'(bus.req_ready), 64'(4'b0010));
        step();
        chk_xfer("lk_f2", 1, 2, 1'b0);
        bus.req_tail = 4'b0111;
        #1;
        chk("lk_ready3", 64'(bus.req_ready), 64'(4'b0010));
        chk("lk_busy3",  64'(bus.busy),      64'(1));
        step();
        chk_xfer("lk_f3", 1, 1, 1'b1);
        chk("lk_busy_end", 64'(bus.busy), 64'(0));
        bus.req_valid = 4'b0101;
        #1;
        chk("lk_next_ready", 64'(bus.req_ready), 64'(4'b0100));
        step();
        chk_xfer("lk_next", 2, 0, 1'b1);
        bus.req_valid = 4'b0000;
        bus.credit_in = 1'b1;
        repeat (4) step();
        bus.credit_in = 1'b0;
        chk("lk_cnt_back", 64'(bus.credit_cnt), 64'(4));

        // credit exhaustion with requester 3 (ptr now 3)
        bus.req_valid = 4'b1000;
        bus.req_tail  = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cr_ready", 64'(bus.req_ready), 64'(4'b1000));
            step();
            chk_xfer("cr", 3, 3 - k, 1'b1);
        end
        #1;
        chk("cr_empty_ready", 64'(bus.req_ready), 64'(0));
        step();
        chk("cr_empty_valid", 64'(bus.out_valid),  64'(0));
        chk("cr_empty_cnt",   64'(bus.credit_cnt), 64'(0));
        bus.credit_in = 1'b1;
        #1;
        chk("cr_pulse_ready", 64'(bus.req_ready), 64'(0));
        step();
        bus.credit_in = 1'b0;
        chk("cr_pulse_valid", 64'(bus.out_valid),  64'(0));
        chk("cr_pulse_cnt",   64'(bus.credit_cnt), 64'(1));
        #1;
        chk("cr_5th_ready", 64'(bus.req_ready), 64'(4'b1000));
        step();
        chk_xfer("cr_5th", 3, 0, 1'b1);
        bus.req_valid = 4'b0000;

        // simultaneous transfer and credit at credit_cnt=2, then saturation
        bus.credit_in = 1'b1;
        repeat (2) step();
        chk("sim_cnt_pre", 64'(bus.credit_cnt), 64'(2));
        bus.req_valid = 4'b0001;
        #1;
        chk("sim_ready", 64'(bus.req_ready), 64'(4'b0001));
        step();
        chk_xfer("sim", 0, 2, 1'b1);
        bus.req_valid = 4'b0000;
        repeat (2) step();
        chk("sat_cnt4",  64'(bus.credit_cnt), 64'(4));
        chk("sat_err0",  64'(bus.err_credit), 64'(0));
        step();
        bus.credit_in = 1'b0;
        chk("sat_cnt",   64'(bus.credit_cnt), 64'(4));
        chk("sat_err1",  64'(bus.err_credit), 64'(1));
        step();
        chk("sat_err_sticky", 64'(bus.err_credit), 64'(1));

        // reset in LOCKED after the first flit of a packet from requester 2 (ptr now 1)
        bus.req_valid = 4'b0100;
        bus.req_tail  = 4'b1011;
        #1;
        chk("mr_ready", 64'(bus.req_ready), 64'(4'b0100));
        step();
        chk_xfer("mr_f1", 2, 3, 1'b0);
        chk("mr_busy1", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        step();
        chk("mr_busy",  64'(bus.busy),       64'(0));
        chk("mr_cnt",   64'(bus.credit_cnt), 64'(4));
        chk("mr_valid", 64'(bus.out_valid),  64'(0));
        chk("mr_err",   64'(bus.err_credit), 64'(0));
        chk("mr_gid",   64'(bus.grant_id),   64'(0));
        chk("mr_data",  64'(bus.out_data),   64'(0));
        rst = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_tail  = 4'b1111;
        #1;
        chk("mr_ptr0_ready", 64'(bus.req_ready), 64'(4'b0001));
        bus.req_valid = 4'b0000;

`ifdef NOC_ARB_STATS_EN
        // 70000 completed packets from requester 0
        bus.req_valid = 4'b0001;
        bus.credit_in = 1'b0;
        step();
        bus.credit_in = 1'b1;
        repeat (69999) step();
        bus.req_valid = 4'b0000;
        bus.credit_in = 1'b0;
        step();
        chk("st_cnt0",   64'(bus.grant_cnt[15:0]),  64'(4464));
        chk("st_others", 64'(bus.grant_cnt[63:16]), 64'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
